// File: rtl/accumulator.sv
// accumulator: unsigned modulo-2^ACC_W add/subtract accumulator, one-cycle latency.
module accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_sub,
    input  logic [DATA_W-1:0] data_in,
    output logic [ACC_W-1:0]  acc
);
    logic [ACC_W-1:0] acc_d, acc_q, operand;
    always_comb begin
        operand = ACC_W'(data_in);
        acc_d   = add_sub ? acc_q - operand : acc_q + operand;
    end
    always_ff @(posedge clk) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end
    assign acc = acc_q;
endmodule

// File: tb/tb_accumulator.sv
// tb_accumulator: directed vectors feed a queue of expected values; a monitor pops one per edge.
module tb_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        add_sub = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] acc;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    accumulator #(.DATA_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .add_sub(add_sub), .data_in(data_in), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic s, input logic [7:0] d,
                        input logic [15:0] e, input string n);
        exp_t x;
        @(negedge clk);
        rst = r;
        add_sub = s;
        data_in = d;
        x.name = n;
        x.exp = e;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (acc !== e.exp) begin
                    errors++;
                    $display("FAIL %s: acc=%h expected %h", e.name, acc, e.exp);
                end
            end
        end
    end

    initial begin : stimulus
        step(1'b0, 1'b0, 8'hAA, 16'h0000, "reset");
        step(1'b1, 1'b0, 8'h00, 16'h0000, "reset_release");
        step(1'b1, 1'b0, 8'h05, 16'h0005, "add_05");
        step(1'b1, 1'b0, 8'h0A, 16'h000F, "add_0a");
        step(1'b1, 1'b1, 8'h03, 16'h000C, "sub_03");
        step(1'b1, 1'b1, 8'h04, 16'h0008, "sub_04");
        step(1'b0, 1'b1, 8'hFF, 16'h0000, "reset_sub_ff");
        step(1'b1, 1'b1, 8'h01, 16'hFFFF, "wrap_sub_01");
        step(1'b1, 1'b0, 8'h01, 16'h0000, "wrap_add_01");
        step(1'b1, 1'b0, 8'hFF, 16'h00FF, "add_ff");
        step(1'b1, 1'b1, 8'h00, 16'h00FF, "hold_sub");
        step(1'b1, 1'b0, 8'h00, 16'h00FF, "hold_add");
        step(1'b1, 1'b1, 8'h00, 16'h00FF, "hold_sub2");
        step(1'b1, 1'b0, 8'h24, 16'h0123, "add_24");
        step(1'b0, 1'b0, 8'h10, 16'h0000, "mid_reset");
        step(1'b1, 1'b0, 8'h10, 16'h0010, "resume_add_10");
        step(1'b1, 1'b0, 8'hF0, 16'h0100, "add_f0_carry");
        step(1'b1, 1'b1, 8'h80, 16'h0080, "sub_80");
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, operand width in bits.
REQ-002 The block SHALL expose parameter ACC_W, default 16, accumulator width in bits; ACC_W >= DATA_W is required.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-005 Port: rst  input  1  synchronous reset, active-low; sampled on the rising clk edge.
REQ-006 Port: add_sub  input  1  operation select; 0 = add, 1 = subtract.
REQ-007 Port: data_in  input  DATA_W  unsigned operand.
REQ-008 Port: acc  output  ACC_W  accumulator value, driven directly from a register.

Function
REQ-009 acc SHALL be a register updated only on the rising edge of clk.
REQ-010 With rst high and add_sub = 0, acc SHALL load acc + data_in at every rising edge.
REQ-011 With rst high and add_sub = 1, acc SHALL load acc - data_in at every rising edge.
REQ-012 data_in SHALL be zero-extended to ACC_W before the add or subtract.
REQ-013 Arithmetic SHALL be unsigned and modulo 2^ACC_W: no saturation, no overflow or borrow flag.
REQ-014 Addition past 2^ACC_W-1 SHALL wrap; for example, 0xFFFF + 0x01 gives 0x0000.
REQ-015 Subtraction below 0 SHALL wrap; for example, 0x0000 - 0x01 gives 0xFFFF.
REQ-016 Latency SHALL be one cycle: the result of the operands sampled at edge N is visible on acc after edge N.
REQ-017 The block SHALL have no enable: it accumulates every cycle, and data_in = 0 holds acc unchanged for either add_sub value.
REQ-018 add_sub and data_in SHALL be sampled on the same edge; a change between edges takes effect at the next edge only.
REQ-019 acc SHALL have no combinational path from any input.

Reset
REQ-020 When rst is low at a rising clk edge, acc SHALL become 0 at that edge, regardless of add_sub and data_in.
REQ-021 Reset SHALL take priority over accumulation on the same edge.
REQ-022 Reset asserted mid-operation SHALL clear acc on the next edge, and accumulation SHALL resume from 0 at the first edge where rst is high.
REQ-023 Deassertion of rst SHALL not itself modify acc.
REQ-024 acc SHALL be undefined before the first reset edge, and benches SHALL apply reset before checking acc.

Verification
REQ-025 Reset: rst = 0 for 1 edge with data_in = 0xAA, add_sub = 0 -> acc = 0x0000.
REQ-026 Add sequence from 0: add 0x05, then add 0x0A -> acc = 0x0005, then 0x000F, one edge each.
REQ-027 Subtract sequence from 0x000F: subtract 0x03, then subtract 0x04 -> acc = 0x000C, then 0x0008.
REQ-028 Wrap: from 0x0000, subtract 0x01 -> 0xFFFF; then add 0x01 -> 0x0000; then add 0xFF -> 0x00FF.
REQ-029 Hold: data_in = 0 for 3 edges with add_sub toggling -> acc unchanged.
REQ-030 Mid-run reset: from acc = 0x0123, rst = 0 for one edge with data_in = 0x10 -> acc = 0x0000; next edge with rst = 1, add 0x10 -> acc = 0x0010.
